// File: rtl/fdc_code_averager_pkg.sv
// Shared definitions for the FDC code averager and neighbouring FDC blocks.
package fdc_code_averager_pkg;

  // Default code width and log2 of samples per averaging window.
  localparam int unsigned DefW     = 5;
  localparam int unsigned DefLog2N = 3;

  // Averager control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StAcc   = 2'd2
  } fdc_avg_state_e;

endpackage

// File: rtl/fdc_code_sync.sv
// Resynchronises the asynchronous FDC code bus and select line into the clk domain and flags
// when the synchronised code has held the same value long enough to be trusted.
module fdc_code_sync
  import fdc_code_averager_pkg::*;
#(
  parameter int unsigned W      = DefW,
  parameter int unsigned STABLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] fdc_code,
  input  logic         selec,
  output logic [W-1:0] code_s,
  output logic         sel_s,
  output logic         stable
);

  localparam int unsigned RunW = $clog2(STABLE + 1);

  logic [W-1:0]    code_meta;
  logic [W-1:0]    code_prev;
  logic            sel_meta;
  logic [RunW-1:0] run_q;
  logic [RunW-1:0] run_d;

  // Run length of equal synchronised codes including the current cycle, so a one-cycle
  // glitch at code_s is never reported as settled.
  always_comb begin
    run_d = '0;
    if (code_s != code_prev) begin
      run_d = '0;
    end else if (run_q == RunW'(STABLE)) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RunW'(1);
    end
  end

  assign stable = (run_d == RunW'(STABLE));

  // Two-flop synchronisers plus the settle-filter history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_meta <= '0;
      code_s    <= '0;
      code_prev <= '0;
      sel_meta  <= 1'b0;
      sel_s     <= 1'b0;
      run_q     <= '0;
    end else begin
      code_meta <= fdc_code;
      code_s    <= code_meta;
      code_prev <= code_s;
      sel_meta  <= selec;
      sel_s     <= sel_meta;
      run_q     <= run_d;
    end
  end

endmodule

// File: rtl/fdc_code_averager.sv
// Decimates settled FDC codes into samples and reports mean/min/max per window of 2^LOG2_N.
// A change of the synchronised converter select discards the partial window.
module fdc_code_averager
  import fdc_code_averager_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned LOG2_N     = DefLog2N,
  parameter int unsigned STABLE     = 2,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         selec,
  input  logic [W-1:0] fdc_code,
  output logic [W-1:0] avg_code,
  output logic [W-1:0] min_code,
  output logic [W-1:0] max_code,
  output logic         result_sel,
  output logic         result_valid,
  output logic         busy
);

  localparam int unsigned N    = 1 << LOG2_N;
  localparam int unsigned AccW = W + LOG2_N;
  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [W-1:0]      code_s;
  logic              sel_s;
  logic              stable;

  fdc_avg_state_e    state_q, state_d;
  logic [AccW-1:0]   acc_q;
  logic [LOG2_N-1:0] cnt_q;
  logic [DivW-1:0]   div_q;
  logic              pending_q;
  logic [W-1:0]      min_q, max_q;
  logic              window_sel_q;
  logic              sel_prev_q;

  logic              sel_edge, div_wrap, accept, last;
  logic [AccW-1:0]   acc_sum;
  logic [W-1:0]      min_new, max_new;

  fdc_code_sync #(
    .W      (W),
    .STABLE (STABLE)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .fdc_code (fdc_code),
    .selec    (selec),
    .code_s   (code_s),
    .sel_s    (sel_s),
    .stable   (stable)
  );

  // Sample-accept decode; enable and select edges take priority over an accept.
  always_comb begin
    sel_edge = (sel_s != sel_prev_q);
    div_wrap = (state_q == StAcc) && (div_q == DivW'(SAMPLE_DIV - 1));
    accept   = (state_q == StAcc) && enable && !sel_edge && pending_q && stable;
    last     = accept && (cnt_q == LOG2_N'(N - 1));
    acc_sum  = acc_q + AccW'(code_s);
    min_new  = (code_s < min_q) ? code_s : min_q;
    max_new  = (code_s > max_q) ? code_s : max_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StClear;
        StClear: state_d = sel_edge ? StClear : StAcc;
        StAcc:   state_d = sel_edge ? StClear : StAcc;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Window accumulator, sample tick and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      div_q        <= '0;
      pending_q    <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      window_sel_q <= 1'b0;
      sel_prev_q   <= 1'b0;
      avg_code     <= '0;
      min_code     <= '0;
      max_code     <= '0;
      result_sel   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      sel_prev_q   <= sel_s;
      result_valid <= 1'b0;
      // With enable low everything is frozen; CLEAR re-initialises on the way back in.
      if (enable) begin
        if (state_q == StClear) begin
          acc_q        <= '0;
          cnt_q        <= '0;
          div_q        <= '0;
          pending_q    <= 1'b0;
          min_q        <= '1;
          max_q        <= '0;
          window_sel_q <= sel_s;
        end else if (state_q == StAcc) begin
          div_q <= div_wrap ? '0 : div_q + DivW'(1);
          // A wrap while a sample is still pending is absorbed.
          if (accept) begin
            pending_q <= 1'b0;
          end else if (div_wrap) begin
            pending_q <= 1'b1;
          end
          if (last) begin
            avg_code     <= acc_sum[AccW-1:LOG2_N];
            min_code     <= min_new;
            max_code     <= max_new;
            result_sel   <= window_sel_q;
            result_valid <= 1'b1;
            acc_q        <= '0;
            cnt_q        <= '0;
            min_q        <= '1;
            max_q        <= '0;
          end else if (accept) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + LOG2_N'(1);
            min_q <= min_new;
            max_q <= max_new;
          end
        end
      end
    end
  end

  assign busy = (state_q == StAcc);

endmodule

// File: tb/tb_fdc_code_averager.sv
// Scenario bench for fdc_code_averager: expected windows are queued as stimulus is applied
// and checked by a monitor whenever result_valid pulses.
module tb_fdc_code_averager;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       selec;
  logic [4:0] fdc_code;
  logic [4:0] avg_code, min_code, max_code;
  logic       result_sel, result_valid, busy;

  typedef struct packed {
    logic [4:0] avg;
    logic [4:0] mn;
    logic [4:0] mx;
    logic       sel;
  } res_t;

  res_t        exp_q[$];
  int unsigned valid_cyc[$];
  int unsigned cyc   = 0;
  int          tests = 0;
  int          fails = 0;
  res_t        mon_exp;

  fdc_code_averager dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .selec        (selec),
    .fdc_code     (fdc_code),
    .avg_code     (avg_code),
    .min_code     (min_code),
    .max_code     (max_code),
    .result_sel   (result_sel),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pulse must match the oldest queued window.
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      valid_cyc.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got avg=%0d min=%0d max=%0d sel=%0d, required no result",
                 avg_code, min_code, max_code, result_sel);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({avg_code, min_code, max_code, result_sel} !== mon_exp) begin
          fails++;
          $display("FAIL window: got avg=%0d min=%0d max=%0d sel=%0d, required avg=%0d min=%0d max=%0d sel=%0d",
                   avg_code, min_code, max_code, result_sel,
                   mon_exp.avg, mon_exp.mn, mon_exp.mx, mon_exp.sel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for all queued windows; an expired bound counts as a failure.
  task automatic drain(input int max_cyc, input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d windows outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; selec = 1'b0; fdc_code = '0;
    idle(3);
    tests += 6;
    if (avg_code !== 5'd0)   begin fails++; $display("FAIL reset_avg: got %0d, required 0", avg_code); end
    if (min_code !== 5'd0)   begin fails++; $display("FAIL reset_min: got %0d, required 0", min_code); end
    if (max_code !== 5'd0)   begin fails++; $display("FAIL reset_max: got %0d, required 0", max_code); end
    if (result_sel !== 1'b0) begin fails++; $display("FAIL reset_sel: got %0d, required 0", result_sel); end
    if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0d, required 0", result_valid); end
    if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %0d, required 0", busy); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_constant();
    int unsigned start;
    fdc_code = 5'd12; selec = 1'b1;
    idle(8);
    valid_cyc.delete();
    enable = 1'b1;
    start  = cyc;
    for (int i = 0; i < 3; i++) exp_q.push_back('{avg: 5'd12, mn: 5'd12, mx: 5'd12, sel: 1'b1});
    idle(1);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_in_clear: got %0d, required 0", busy); end
    idle(1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_acc: got %0d, required 1", busy); end
    drain(120, "constant");
    tests += 2;
    if (valid_cyc.size() < 3) begin
      fails += 2;
      $display("FAIL constant_pulses: got %0d pulses, required 3", valid_cyc.size());
    end else begin
      if (valid_cyc[0] !== start + 35) begin
        fails++;
        $display("FAIL first_valid_cycle: got %0d, required %0d", valid_cyc[0] - start, 35);
      end
      if (valid_cyc[2] - valid_cyc[1] !== 32) begin
        fails++;
        $display("FAIL valid_period: got %0d, required 32", valid_cyc[2] - valid_cyc[1]);
      end
    end
    enable = 1'b0;
    idle(3);
    tests += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0d, required 0", busy); end
    if (avg_code !== 5'd12) begin fails++; $display("FAIL idle_hold_avg: got %0d, required 12", avg_code); end
  endtask

  // Two accepts per value in a 10,10,13,13 cycle: every window holds four of each (sum 92).
  task automatic test_alternate();
    fdc_code = 5'd10;
    idle(8);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) exp_q.push_back('{avg: 5'd11, mn: 5'd10, mx: 5'd13, sel: 1'b1});
    idle(11);
    fdc_code = 5'd13;
    for (int i = 0; i < 7; i++) begin
      idle(8);
      fdc_code = (fdc_code == 5'd13) ? 5'd10 : 5'd13;
    end
    drain(40, "alternate");
    enable = 1'b0;
    idle(3);
  endtask

  task automatic test_all_max();
    fdc_code = 5'd31;
    idle(8);
    enable = 1'b1;
    exp_q.push_back('{avg: 5'd31, mn: 5'd31, mx: 5'd31, sel: 1'b1});
    drain(60, "all_max");
    enable = 1'b0;
    idle(3);
  endtask

  task automatic test_glitch();
    fdc_code = 5'd4;
    idle(8);
    enable = 1'b1;
    exp_q.push_back('{avg: 5'd4, mn: 5'd4, mx: 5'd4, sel: 1'b1});
    for (int i = 0; i < 4; i++) begin
      idle(8);
      fdc_code = 5'd31;
      idle(1);
      fdc_code = 5'd4;
    end
    drain(60, "glitch");
    enable = 1'b0;
    idle(3);
  endtask

  // Select toggles after the fifth accept; the new window must be made only of fresh samples.
  task automatic test_sel_flush();
    int unsigned start;
    fdc_code = 5'd7; selec = 1'b0;
    idle(8);
    valid_cyc.delete();
    enable = 1'b1;
    start  = cyc;
    idle(23);
    selec    = 1'b1;
    fdc_code = 5'd9;
    exp_q.push_back('{avg: 5'd9, mn: 5'd9, mx: 5'd9, sel: 1'b1});
    drain(80, "sel_flush");
    tests++;
    if (valid_cyc.size() < 1 || valid_cyc[0] !== start + 60) begin
      fails++;
      $display("FAIL flush_restart_cycle: got %0d, required %0d",
               (valid_cyc.size() < 1) ? 0 : valid_cyc[0] - start, 60);
    end
    enable = 1'b0;
    idle(3);
  endtask

  task automatic test_reset_mid();
    int unsigned start;
    fdc_code = 5'd5;
    enable   = 1'b1;
    idle(15);
    #2 reset = 1'b1;
    #1;
    tests += 5;
    if (avg_code !== 5'd0)   begin fails++; $display("FAIL midreset_avg: got %0d, required 0", avg_code); end
    if (min_code !== 5'd0)   begin fails++; $display("FAIL midreset_min: got %0d, required 0", min_code); end
    if (max_code !== 5'd0)   begin fails++; $display("FAIL midreset_max: got %0d, required 0", max_code); end
    if (result_sel !== 1'b0) begin fails++; $display("FAIL midreset_sel: got %0d, required 0", result_sel); end
    if (busy !== 1'b0)       begin fails++; $display("FAIL midreset_busy: got %0d, required 0", busy); end
    @(negedge clk);
    valid_cyc.delete();
    reset = 1'b0;
    start = cyc;
    exp_q.push_back('{avg: 5'd5, mn: 5'd5, mx: 5'd5, sel: 1'b1});
    drain(80, "reset_mid");
    tests++;
    if (valid_cyc.size() < 1 || valid_cyc[0] < start + 35) begin
      fails++;
      $display("FAIL reset_full_window: got %0d, required at least 35",
               (valid_cyc.size() < 1) ? 0 : valid_cyc[0] - start);
    end
    enable = 1'b0;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternate();
    test_all_max();
    test_glitch();
    test_sel_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
